// File: rtl/boardman_tx_arbiter.sv
// boardman_tx_arbiter
//   Packet-granular arbiter that shares the COBS encoder / UART TX path
//   between two 8-bit AXI4-Stream packet sources. Whole packets are never
//   interleaved, packets longer than MAX_LEN are cut (forced tlast, tail
//   discarded) and a flush pulse drops a half-sent packet cleanly.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   flush               single-cycle abort pulse
//   s_axis_tx0_*        source 0 (tdata/tvalid/tready/tlast)
//   s_axis_tx1_*        source 1 (tdata/tvalid/tready/tlast)
//   m_axis_tx_*         output stream towards the encoder
//   active              a packet is granted (PASS or DISCARD)
//   grant               granted / last-granted port index
//   trunc_count         saturating count of truncated packets
//   abort_count         saturating count of flushed packets
//
// Parameters
//   MAX_LEN             maximum bytes per output packet (2..65535)
//   PRIORITY_MODE       0 = round-robin, 1 = port 0 always wins

module boardman_tx_arbiter #(
  parameter int unsigned MAX_LEN       = 256,
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic [7:0] s_axis_tx0_tdata,
  input  logic       s_axis_tx0_tvalid,
  output logic       s_axis_tx0_tready,
  input  logic       s_axis_tx0_tlast,
  input  logic [7:0] s_axis_tx1_tdata,
  input  logic       s_axis_tx1_tvalid,
  output logic       s_axis_tx1_tready,
  input  logic       s_axis_tx1_tlast,
  output logic [7:0] m_axis_tx_tdata,
  output logic       m_axis_tx_tvalid,
  input  logic       m_axis_tx_tready,
  output logic       m_axis_tx_tlast,
  output logic       active,
  output logic       grant,
  output logic [7:0] trunc_count,
  output logic [7:0] abort_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PASS    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(MAX_LEN - 1);

  state_t      r_state, w_state_nxt;
  logic        r_grant, w_grant_nxt;
  logic [15:0] r_cnt,   w_cnt_nxt;
  logic [7:0]  r_trunc, w_trunc_nxt;
  logic [7:0]  r_abort, w_abort_nxt;

  // Granted source, muxed once and shared by both combinational processes
  logic [7:0] w_tdata;
  logic       w_tvalid;
  logic       w_tlast;
  logic       w_at_max;
  logic       w_winner;
  logic       w_other_valid;
  logic       w_tready_g;

  always_comb begin
    w_tdata  = r_grant ? s_axis_tx1_tdata  : s_axis_tx0_tdata;
    w_tvalid = r_grant ? s_axis_tx1_tvalid : s_axis_tx0_tvalid;
    w_tlast  = r_grant ? s_axis_tx1_tlast  : s_axis_tx0_tlast;
    w_at_max = (r_cnt == LAST_IDX);
  end

  // Round-robin: the port that did not win last time goes first if it is
  // asking; otherwise the only requester is the last-granted port itself.
  always_comb begin
    w_other_valid = r_grant ? s_axis_tx0_tvalid : s_axis_tx1_tvalid;
    if (PRIORITY_MODE == 1) begin
      w_winner = ~s_axis_tx0_tvalid;
    end else begin
      w_winner = w_other_valid ? ~r_grant : r_grant;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= 1'b1;
      r_cnt   <= '0;
      r_trunc <= '0;
      r_abort <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
      r_trunc <= w_trunc_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    w_trunc_nxt = r_trunc;
    w_abort_nxt = r_abort;
    unique case (r_state)
      IDLE: begin
        if (!flush && (s_axis_tx0_tvalid || s_axis_tx1_tvalid)) begin
          w_state_nxt = PASS;
          w_grant_nxt = w_winner;
          w_cnt_nxt   = '0;
        end
      end
      PASS: begin
        if (flush) begin
          w_state_nxt = DISCARD;
          w_cnt_nxt   = '0;
          if (r_abort != 8'hFF) w_abort_nxt = r_abort + 8'd1;
        end else if (w_tvalid && m_axis_tx_tready) begin
          w_cnt_nxt = r_cnt + 16'd1;
          // Source tlast is checked first so an exact-MAX_LEN packet is
          // not counted as a truncation.
          if (w_tlast) begin
            w_state_nxt = IDLE;
          end else if (w_at_max) begin
            w_state_nxt = DISCARD;
            if (r_trunc != 8'hFF) w_trunc_nxt = r_trunc + 8'd1;
          end
        end
      end
      DISCARD: begin
        if (!flush && w_tvalid && w_tlast) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_tready_g       = 1'b0;
    m_axis_tx_tdata  = w_tdata;
    m_axis_tx_tvalid = 1'b0;
    m_axis_tx_tlast  = 1'b0;
    unique case (r_state)
      PASS: begin
        m_axis_tx_tvalid = w_tvalid && !flush;
        m_axis_tx_tlast  = w_tlast || w_at_max;
        w_tready_g       = m_axis_tx_tready && !flush;
      end
      // tready is held low during a flush here too, so a beat is never
      // consumed in a cycle whose state transition is suppressed.
      DISCARD: w_tready_g = !flush;
      default: w_tready_g = 1'b0;
    endcase
    s_axis_tx0_tready = w_tready_g && !r_grant;
    s_axis_tx1_tready = w_tready_g &&  r_grant;
  end

  assign active      = (r_state != IDLE);
  assign grant       = r_grant;
  assign trunc_count = r_trunc;
  assign abort_count = r_abort;

endmodule

// File: tb/tb_boardman_tx_arbiter.sv
module tb_boardman_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [7:0] s0_tdata, s1_tdata, m_tdata;
  logic       s0_tvalid, s0_tready, s0_tlast;
  logic       s1_tvalid, s1_tready, s1_tlast;
  logic       m_tvalid, m_tready, m_tlast;
  logic       active, grant;
  logic [7:0] trunc_count, abort_count;

  int n_cmp = 0;
  int n_err = 0;

  // Source models: byte idx of a stream of len bytes, data = base + idx*step,
  // tlast every plen bytes.
  int idx0, len0, plen0, base0, step0;
  int idx1, len1, plen1, base1, step1;

  logic [7:0] cap_d[$];
  logic       cap_l[$];
  logic [7:0] exp_d[$];
  logic       exp_l[$];

  boardman_tx_arbiter #(.MAX_LEN(4), .PRIORITY_MODE(0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_axis_tx0_tdata(s0_tdata), .s_axis_tx0_tvalid(s0_tvalid),
    .s_axis_tx0_tready(s0_tready), .s_axis_tx0_tlast(s0_tlast),
    .s_axis_tx1_tdata(s1_tdata), .s_axis_tx1_tvalid(s1_tvalid),
    .s_axis_tx1_tready(s1_tready), .s_axis_tx1_tlast(s1_tlast),
    .m_axis_tx_tdata(m_tdata), .m_axis_tx_tvalid(m_tvalid),
    .m_axis_tx_tready(m_tready), .m_axis_tx_tlast(m_tlast),
    .active(active), .grant(grant),
    .trunc_count(trunc_count), .abort_count(abort_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    s0_tvalid = (idx0 < len0);
    s0_tdata  = 8'(base0 + idx0 * step0);
    s0_tlast  = ((idx0 % plen0) == plen0 - 1);
    s1_tvalid = (idx1 < len1);
    s1_tdata  = 8'(base1 + idx1 * step1);
    s1_tlast  = ((idx1 % plen1) == plen1 - 1);
  endtask

  task automatic start0(input int len, input int plen, input int base, input int step);
    idx0 = 0; len0 = len; plen0 = plen; base0 = base; step0 = step;
    drive(); #1;
  endtask

  task automatic start1(input int len, input int plen, input int base, input int step);
    idx1 = 0; len1 = len; plen1 = plen; base1 = base; step1 = step;
    drive(); #1;
  endtask

  // Records the handshakes seen just before the edge, advances the sources.
  task automatic tick();
    logic hs0, hs1;
    hs0 = s0_tvalid && s0_tready;
    hs1 = s1_tvalid && s1_tready;
    if (m_tvalid && m_tready) begin
      cap_d.push_back(m_tdata);
      cap_l.push_back(m_tlast);
    end
    @(posedge clk); #1;
    if (hs0) idx0++;
    if (hs1) idx1++;
    drive();
    #1;
  endtask

  task automatic exp_push(input logic [7:0] d, input logic l);
    exp_d.push_back(d);
    exp_l.push_back(l);
  endtask

  task automatic chk_capture(input string tag);
    chk({tag, "_count"}, cap_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), cap_d[i], exp_d[i]);
      chk($sformatf("%s_last%0d", tag, i), cap_l[i], exp_l[i]);
    end
    cap_d.delete(); cap_l.delete();
    exp_d.delete(); exp_l.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_grant"}, grant, 1);
    chk({tag, "_trunc"}, trunc_count, 0);
    chk({tag, "_abort"}, abort_count, 0);
    chk({tag, "_rdy0"}, s0_tready, 0);
    chk({tag, "_rdy1"}, s1_tready, 0);
    chk({tag, "_mvalid"}, m_tvalid, 0);
    chk({tag, "_mlast"}, m_tlast, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; m_tready = 1'b1;
    idx0 = 0; len0 = 0; plen0 = 1; base0 = 0; step0 = 1;
    idx1 = 0; len1 = 0; plen1 = 1; base1 = 0; step1 = 1;
    drive();
    #2;
    chk_reset_vals("reset");
    @(negedge clk); rst = 1'b0;
    tick();

    // Single 3-byte packet from src0
    start0(3, 3, 'h11, 'h11);
    chk("t1_bubble_active", active, 0);
    chk("t1_bubble_mvalid", m_tvalid, 0);
    chk("t1_bubble_rdy0", s0_tready, 0);
    tick();
    chk("t1_active", active, 1);
    chk("t1_grant", grant, 0);
    chk("t1_mvalid", m_tvalid, 1);
    chk("t1_mdata", m_tdata, 'h11);
    chk("t1_rdy0", s0_tready, 1);
    chk("t1_rdy1", s1_tready, 0);
    tick(); tick();
    chk("t1_last", m_tlast, 1);
    tick();
    chk("t1_idle", active, 0);
    chk("t1_grant_hold", grant, 0);
    exp_push('h11, 0); exp_push('h22, 0); exp_push('h33, 1);
    chk_capture("t1");

    // Round-robin contention after a fresh reset
    #2 rst = 1'b1; #1;
    chk_reset_vals("rst2");
    @(negedge clk); rst = 1'b0;
    tick();
    start0(8, 2, 'hA0, 1);
    start1(8, 2, 'hB0, 1);
    tick();
    chk("t2_first_grant", grant, 0);
    for (int k = 0; k < 60; k++) begin
      if (idx0 == 8 && idx1 == 8 && !active) break;
      tick();
    end
    chk("t2_done", (idx0 == 8 && idx1 == 8 && !active), 1);
    for (int p = 0; p < 8; p++) begin
      exp_push(8'(((p % 2) ? 'hB0 : 'hA0) + 2 * (p / 2)), 0);
      exp_push(8'(((p % 2) ? 'hB0 : 'hA0) + 2 * (p / 2) + 1), 1);
    end
    chk_capture("t2");

    // Truncation: 6-byte packet from src1 with MAX_LEN = 4
    start1(6, 6, 'h31, 1);
    tick(); tick(); tick(); tick();
    chk("t3_forced_last", m_tlast, 1);
    chk("t3_src_last", s1_tlast, 0);
    tick();
    chk("t3_disc_mvalid", m_tvalid, 0);
    chk("t3_disc_rdy1", s1_tready, 1);
    chk("t3_disc_active", active, 1);
    chk("t3_trunc", trunc_count, 1);
    tick(); tick();
    chk("t3_idle", active, 0);
    chk("t3_drained", idx1, 6);
    exp_push('h31, 0); exp_push('h32, 0); exp_push('h33, 0); exp_push('h34, 1);
    chk_capture("t3");

    // Exact MAX_LEN packet is not a truncation
    start0(4, 4, 'h41, 1);
    tick(); tick(); tick(); tick();
    chk("t4_last", m_tlast, 1);
    tick();
    chk("t4_idle", active, 0);
    chk("t4_trunc_same", trunc_count, 1);
    exp_push('h41, 0); exp_push('h42, 0); exp_push('h43, 0); exp_push('h44, 1);
    chk_capture("t4");

    // Flush after byte 2 of a 5-byte packet
    start1(5, 5, 'h51, 1);
    tick(); tick(); tick();
    flush = 1'b1; #1;
    chk("t5_flush_mvalid", m_tvalid, 0);
    chk("t5_flush_rdy1", s1_tready, 0);
    tick();
    flush = 1'b0; #1;
    chk("t5_abort", abort_count, 1);
    chk("t5_disc_active", active, 1);
    chk("t5_disc_mvalid", m_tvalid, 0);
    chk("t5_disc_rdy1", s1_tready, 1);
    tick(); tick(); tick();
    chk("t5_idle", active, 0);
    chk("t5_drained", idx1, 5);
    exp_push('h51, 0); exp_push('h52, 0);
    chk_capture("t5");

    // Flush in IDLE suppresses arbitration; next packet forwarded normally
    start0(2, 2, 'h61, 1);
    flush = 1'b1; #1;
    tick();
    flush = 1'b0; #1;
    chk("t5b_suppressed", active, 0);
    chk("t5b_abort_same", abort_count, 1);
    tick();
    chk("t5b_active", active, 1);
    chk("t5b_grant", grant, 0);
    tick(); tick();
    chk("t5b_idle", active, 0);
    exp_push('h61, 0); exp_push('h62, 1);
    chk_capture("t5b");

    // Backpressure: m tready low 3 cycles mid-packet
    start0(3, 3, 'h71, 1);
    tick(); tick();
    m_tready = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t6_hold_data%0d", k), m_tdata, 'h72);
      chk($sformatf("t6_hold_valid%0d", k), m_tvalid, 1);
      chk($sformatf("t6_hold_rdy%0d", k), s0_tready, 0);
      tick();
    end
    chk("t6_no_advance", idx0, 1);
    m_tready = 1'b1; #1;
    tick(); tick();
    chk("t6_idle", active, 0);
    exp_push('h71, 0); exp_push('h72, 0); exp_push('h73, 1);
    chk_capture("t6");

    // Asynchronous reset mid-packet, checked between clock edges
    start1(3, 3, 'h81, 1);
    tick(); tick();
    chk("t7_pre_active", active, 1);
    #2 rst = 1'b1; #1;
    chk_reset_vals("t7_async");
    len1 = 0; drive();
    @(negedge clk); rst = 1'b0;
    tick();
    chk("t7_after_idle", active, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
